apb_completer: RTL
==================

APB_COMPLETER -- requirements
Module: apb_completer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width; only 32 supported.
REQ-003 SHALL have parameter MEM_DEPTH, default 16, number of 32-bit words stored.
REQ-004 SHALL have parameter WAIT_STATES, default 1, access-phase cycles with pready low, range 0..7.
REQ-005 SHALL have port pclk, input, 1, the single clock, rising-edge active.
REQ-006 SHALL have port presetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports psel, penable, pwrite, input, 1 each, APB select, enable and direction (1 = write).
REQ-008 SHALL have port paddr, input, ADDR_WIDTH, byte address.
REQ-009 SHALL have port pwdata, input, DATA_WIDTH, write data.
REQ-010 SHALL have port pstrb, input, DATA_WIDTH/8, write byte strobes.
REQ-011 SHALL have port pprot, input, 3, protection attributes.
REQ-012 SHALL have ports prdata (DATA_WIDTH), pready (1) and pslverr (1), outputs carrying read data, transfer completion and error.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS and ABORT.
REQ-014 SHALL go IDLE->ACCESS on an edge sampling psel=1, penable=0, latching paddr, pwrite, pwdata, pstrb, pprot and a wait counter cleared to 0.
REQ-015 SHALL, in ACCESS, go to ABORT on any edge sampling psel=0 or penable=0, with no memory update.
REQ-016 SHALL, in ACCESS, increment the wait counter each edge while counter<WAIT_STATES.
REQ-017 SHALL drive pready=1 in ACCESS exactly when counter==WAIT_STATES, giving total latency of WAIT_STATES+1 access cycles.
REQ-018 SHALL complete the transfer on the edge where pready=1, returning to IDLE; if that same edge samples psel=1 and penable=0, it SHALL instead re-enter ACCESS (back-to-back).
REQ-019 SHALL in ABORT drive pready=1 and pslverr=1 for one cycle, then return to IDLE.
REQ-020 SHALL flag an error on the latched transfer when paddr[1:0]!=0 (unaligned).
REQ-021 SHALL flag an error when the word index is >= MEM_DEPTH, or when any bit between the index field and the region bits is nonzero.
REQ-022 SHALL flag an error on protection: paddr[ADDR_WIDTH-1]=1 (privileged) with pprot[0]=0; paddr[ADDR_WIDTH-2]=1 (non-secure) with pprot[1]=0; paddr[ADDR_WIDTH-3]=1 (instruction) with pprot[2]=0.
REQ-023 SHALL use word index paddr[clog2(MEM_DEPTH)+1:2]; region bits do not alter the index.
REQ-024 SHALL drive pslverr=1 only while pready=1 and the transfer is errored or aborted; otherwise 0.
REQ-025 SHALL, for an error-free write, update only the bytes whose pstrb bit is 1, at the completion edge.
REQ-026 SHALL suppress the memory update for an errored write.
REQ-027 SHALL drive prdata with the addressed word while pready=1 for an error-free read, and 0 at all other times, including errored reads and writes.
REQ-028 SHALL drive pready, pslverr and prdata from state and registers only, with no combinational path from APB inputs.

Reset
REQ-029 SHALL on presetn=0 immediately force state IDLE, counter 0, pready=0, pslverr=0, prdata=0 and all memory words to 0.
REQ-030 SHALL treat reset during ACCESS or ABORT as discarding the transfer, with no partial write.

Structure
REQ-031 SHALL place the state enum, the region bit positions and the pprot-versus-address check function in apb_pkg, shared with the bridge testbench.
REQ-032 SHALL implement the byte-strobed storage as one sub-module, apb_completer_mem.

Verification
REQ-033 Bench SHALL cover: write 0xDEADBEEF to 0x4 with pstrb=0xF and pprot=0, then read 0x4 -> pready after 2 access cycles, prdata=0xDEADBEEF, pslverr=0.
REQ-034 Bench SHALL cover: psel dropped while penable=1 at 0x4 -> next cycle pready=1 and pslverr=1, and memory is unchanged.
REQ-035 Bench SHALL cover: read at 0x3 -> pslverr=1, prdata=0.
REQ-036 Bench SHALL cover: address 0xE0000004, pprot=3'b111 -> ok; then pprot=3'b110, 3'b101 and 3'b011 each -> pslverr=1.
REQ-037 Bench SHALL cover: write 0x11223344 with pstrb=0x5 over 0 -> read returns 0x00220044; a write to 0x40 -> pslverr=1, memory unchanged.
REQ-038 Bench SHALL cover: presetn asserted mid-ACCESS -> all outputs 0, and a following read of 0x4 returns 0.

Source files
------------

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB completer and the bridge testbench:
//   - apb_state_e    : completer FSM states
//   - *_OFS          : region bit positions, counted down from the address MSB
//   - prot_violation : pprot-versus-address-region check
// No ports (package).
// -----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ABORT  = 2'd2
    } apb_state_e;

    // Region bits sit at paddr[ADDR_WIDTH-OFS]; the order matches pprot[2:0].
    localparam int unsigned PRIV_OFS    = 32'd1;  // privileged   <-> pprot[0]
    localparam int unsigned NS_OFS      = 32'd2;  // non-secure   <-> pprot[1]
    localparam int unsigned INSTR_OFS   = 32'd3;  // instruction  <-> pprot[2]
    localparam int unsigned REGION_BITS = 32'd3;

    // A region bit that is set demands the matching pprot bit; any region bit
    // set without its pprot bit is a protection violation.
    function automatic logic prot_violation(input logic [2:0] region,
                                            input logic [2:0] prot);
        return |(region & ~prot);
    endfunction

endpackage

// File: rtl/apb_completer_if.sv
// -----------------------------------------------------------------------------
// apb_completer_if
// APB bus bundle between a requester (master) and the completer (slave).
//   psel, penable, pwrite : select, enable, direction (1 = write)
//   paddr                 : byte address
//   pwdata, pstrb         : write data and byte strobes
//   pprot                 : protection attributes
//   prdata, pready, pslverr : read data, completion, error (completer driven)
// -----------------------------------------------------------------------------
interface apb_completer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [2:0]                pprot;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_completer_mem.sv
// -----------------------------------------------------------------------------
// apb_completer_mem
// Byte-strobed word storage, cleared by reset.
//   clk, rst_n : clock, asynchronous active-low reset (clears every word)
//   wr_en      : commit wr_data bytes selected by wr_strb into word wr_idx
//   rd_idx     : combinational read address, rd_data returns that word
//                (zero for an index beyond the storage)
// -----------------------------------------------------------------------------
module apb_completer_mem #(
    parameter int MEM_DEPTH  = 16,
    parameter int IDX_W      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_data
);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_r [0:MEM_DEPTH-1];
    logic                  rd_in_range_s;

    // Storage: reset clears all words; writes update only strobed bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_strb[b]) begin
                    mem_r[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_in_range_s = (32'(rd_idx) < 32'(MEM_DEPTH));
    assign rd_data       = rd_in_range_s ? mem_r[rd_idx] : {DATA_WIDTH{1'b0}};

endmodule

// File: rtl/apb_completer.sv
// -----------------------------------------------------------------------------
// apb_completer
// APB completer with WAIT_STATES access-phase wait cycles, address / alignment
// / protection checking and a byte-strobed word memory.
//   pclk    : clock, rising edge
//   presetn : asynchronous active-low reset
//   bus     : APB slave modport (psel, penable, pwrite, paddr, pwdata, pstrb,
//             pprot in; prdata, pready, pslverr out)
// pready, pslverr and prdata are flops loaded from the next-state values, so
// no APB input reaches an output without passing a register.
// -----------------------------------------------------------------------------
module apb_completer
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic           pclk,
    input  logic           presetn,
    apb_completer_if.slave bus
);
    localparam int NB      = DATA_WIDTH / 8;
    localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int IDX_LSB = 2;
    localparam int IDX_MSB = IDX_W + 1;
    // Bits between the index field and the region bits must be zero.
    localparam int GAP_LSB = IDX_W + 2;
    localparam int GAP_MSB = ADDR_WIDTH - 1 - int'(REGION_BITS);
    localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

    // Decode one transfer's address and protection into a single error flag.
    function automatic logic addr_error(input logic [ADDR_WIDTH-1:0] a,
                                        input logic [2:0]            prot);
        logic [IDX_W-1:0] idx;
        logic [2:0]       region;
        logic             err;
        idx    = a[IDX_MSB:IDX_LSB];
        region = {a[ADDR_WIDTH-int'(INSTR_OFS)],
                  a[ADDR_WIDTH-int'(NS_OFS)],
                  a[ADDR_WIDTH-int'(PRIV_OFS)]};
        err    = (a[1:0] != 2'b00);
        err    = err | (32'(idx) >= 32'(MEM_DEPTH));
        err    = err | (|a[GAP_MSB:GAP_LSB]);
        err    = err | prot_violation(region, prot);
        return err;
    endfunction

    apb_state_e              state_r, state_nx_s;
    logic [2:0]              cnt_r, cnt_nx_s;
    logic                    take_s;     // latch a new transfer this edge
    logic                    commit_s;   // current transfer completes this edge

    logic                    write_r, write_nx_s;
    logic [IDX_W-1:0]        idx_r, idx_nx_s;
    logic [DATA_WIDTH-1:0]   wdata_r, wdata_nx_s;
    logic [NB-1:0]           strb_r, strb_nx_s;
    logic                    err_r, err_nx_s;

    logic                    pready_r, pready_nx_s;
    logic                    pslverr_r, pslverr_nx_s;
    logic [DATA_WIDTH-1:0]   prdata_r, prdata_nx_s;

    logic                    wr_en_s;
    logic [DATA_WIDTH-1:0]   mem_rd_s;
    logic [DATA_WIDTH-1:0]   fwd_rd_s;
    logic                    ready_nx_s;

    // FSM state and wait counter register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // FSM next state: setup detection, wait counting, completion, abort.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        take_s     = 1'b0;
        commit_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    state_nx_s = ACCESS;
                    cnt_nx_s   = 3'd0;
                    take_s     = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == WAIT_CNT) begin
                    // pready is high: complete, or chain straight into a new
                    // transfer if the requester already presents its setup.
                    if (bus.psel && !bus.penable) begin
                        commit_s   = 1'b1;
                        take_s     = 1'b1;
                        state_nx_s = ACCESS;
                        cnt_nx_s   = 3'd0;
                    end else if (bus.psel && bus.penable) begin
                        commit_s   = 1'b1;
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = ABORT;
                    end
                end else if (bus.psel && bus.penable) begin
                    cnt_nx_s = cnt_r + 3'd1;
                end else begin
                    state_nx_s = ABORT;
                end
            end
            ABORT: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = 3'd0;
            end
        endcase
    end

    // Next values of the latched transfer fields.
    always_comb begin
        write_nx_s = take_s ? bus.pwrite : write_r;
        idx_nx_s   = take_s ? bus.paddr[IDX_MSB:IDX_LSB] : idx_r;
        wdata_nx_s = take_s ? bus.pwdata : wdata_r;
        strb_nx_s  = take_s ? bus.pstrb : strb_r;
        err_nx_s   = take_s ? addr_error(bus.paddr, bus.pprot) : err_r;
    end

    // Latched transfer fields register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            write_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            wdata_r <= {DATA_WIDTH{1'b0}};
            strb_r  <= {NB{1'b0}};
            err_r   <= 1'b0;
        end else begin
            write_r <= write_nx_s;
            idx_r   <= idx_nx_s;
            wdata_r <= wdata_nx_s;
            strb_r  <= strb_nx_s;
            err_r   <= err_nx_s;
        end
    end

    // Errored or aborted writes never reach the memory.
    assign wr_en_s = commit_s && write_r && !err_r;

    apb_completer_mem #(
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (pclk),
        .rst_n   (presetn),
        .wr_en   (wr_en_s),
        .wr_idx  (idx_r),
        .wr_data (wdata_r),
        .wr_strb (strb_r),
        .rd_idx  (idx_nx_s),
        .rd_data (mem_rd_s)
    );

    // Read data forwarding: with zero wait states a chained read of the word
    // being written this edge must see the new bytes.
    always_comb begin
        fwd_rd_s = mem_rd_s;
        for (int b = 0; b < NB; b++) begin
            fwd_rd_s[8*b +: 8] = (wr_en_s && (idx_r == idx_nx_s) && strb_r[b])
                                 ? wdata_r[8*b +: 8] : mem_rd_s[8*b +: 8];
        end
    end

    // Next output values, decoded from the next state and latched transfer.
    always_comb begin
        ready_nx_s   = (state_nx_s == ACCESS) && (cnt_nx_s == WAIT_CNT);
        pready_nx_s  = ready_nx_s || (state_nx_s == ABORT);
        pslverr_nx_s = (state_nx_s == ABORT) || (ready_nx_s && err_nx_s);
        prdata_nx_s  = (ready_nx_s && !err_nx_s && !write_nx_s)
                       ? fwd_rd_s : {DATA_WIDTH{1'b0}};
    end

    // Output registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            pready_r  <= pready_nx_s;
            pslverr_r <= pslverr_nx_s;
            prdata_r  <= prdata_nx_s;
        end
    end

    assign bus.pready  = pready_r;
    assign bus.pslverr = pslverr_r;
    assign bus.prdata  = prdata_r;

endmodule
